gcd_job_sequencer: RTL and testbench

Upstream front-end for the GCD core (datapath plus controller). Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. For each pair it drives the core's serial load sequence (A, then B, with `start`), waits for `done`, and returns the result with error status and iteration-cycle count on an output valid/ready stream. It re-arms the core between jobs by pulsing the core's reset, because the core parks in its done state.

---
 rtl/gcd_pkg.sv | 24 ++
 rtl/gcd_pair_fifo.sv | 76 +++++++
 rtl/gcd_job_sequencer.sv | 175 +++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD job sequencer and its operand FIFO.
//   gcd_state_e : sequencer FSM states
//   gcd_err_e   : result status codes reported on out_err
//   GCD_WIDTH   : default operand/result width, matching the core
package gcd_pkg;

    localparam int unsigned GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        REARM,
        IDLE,
        LOAD_A,
        LOAD_B,
        RUN,
        HOLD
    } gcd_state_e;

    typedef enum logic [1:0] {
        GCD_OK      = 2'd0,
        GCD_ZERO    = 2'd1,
        GCD_TIMEOUT = 2'd2
    } gcd_err_e;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Operand-pair FIFO in front of the GCD sequencer.
//   clk, rst_n   : clock, asynchronous active-low reset (clears pointers/count)
//   push_i       : write push_data_i when not full
//   push_data_i  : {a, b} pair, 2*WIDTH bits
//   pop_i        : advance the read pointer when not empty
//   full_o       : all DEPTH entries occupied
//   empty_o      : no entries occupied
//   head_o       : oldest entry (valid when !empty_o)
module gcd_pair_fifo
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [2*WIDTH-1:0] push_data_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [2*WIDTH-1:0] head_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap naturally.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Front-end for the GCD core: buffers operand pairs, drives the core's serial
// load (A with start, then B), waits for done or a RUN-cycle timeout, and
// presents {gcd, err, cycles} on a valid/ready result stream. The core is
// re-armed with a one-cycle core_rst_n pulse after each result is taken.
//   in_valid/in_ready/in_a/in_b            : operand pair stream
//   out_valid/out_ready/out_gcd/out_err/out_cycles : result stream
//   core_rst_n/core_start/core_data        : core control/load
//   core_done/core_result                  : core status/result
module gcd_job_sequencer
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH   = GCD_WIDTH,
    parameter int unsigned DEPTH   = 4,
    parameter logic [15:0] MAX_RUN = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [1:0]       out_err,
    output logic [15:0]      out_cycles,
    output logic             core_rst_n,
    output logic             core_start,
    output logic [WIDTH-1:0] core_data,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result
);

    gcd_state_e         state_q, state_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [15:0]        cnt_q, cnt_d, cnt_inc;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_gcd_q, out_gcd_d;
    logic [1:0]         out_err_q, out_err_d;
    logic [15:0]        out_cycles_q, out_cycles_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               core_start_q, core_start_d;
    logic [WIDTH-1:0]   core_data_q, core_data_d;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [2*WIDTH-1:0] fifo_head;
    logic [WIDTH-1:0]   head_a, head_b;

    gcd_pair_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (in_valid),
        .push_data_i ({in_a, in_b}),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign head_a     = fifo_head[2*WIDTH-1:WIDTH];
    assign head_b     = fifo_head[WIDTH-1:0];
    assign in_ready   = !fifo_full;
    assign out_valid  = out_valid_q;
    assign out_gcd    = out_gcd_q;
    assign out_err    = out_err_q;
    assign out_cycles = out_cycles_q;
    assign core_rst_n = core_rst_n_q;
    assign core_start = core_start_q;
    assign core_data  = core_data_q;

    always_comb begin
        state_d      = state_q;
        op_b_d       = op_b_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_gcd_d    = out_gcd_q;
        out_err_d    = out_err_q;
        out_cycles_d = out_cycles_q;
        core_rst_n_d = 1'b1;
        core_start_d = 1'b0;
        core_data_d  = '0;
        fifo_pop     = 1'b0;
        cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

        unique case (state_q)
            REARM: begin
                state_d = IDLE;
            end
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_b_d   = head_b;
                    cnt_d    = '0;
                    // A zero operand never converges in the core: report it directly.
                    if (head_a == '0 || head_b == '0) begin
                        out_valid_d  = 1'b1;
                        out_gcd_d    = '0;
                        out_err_d    = GCD_ZERO;
                        out_cycles_d = '0;
                        state_d      = HOLD;
                    end else begin
                        // A goes straight into the registered core_data for LOAD_A.
                        core_start_d = 1'b1;
                        core_data_d  = head_a;
                        state_d      = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                core_data_d = op_b_q;
                state_d     = LOAD_B;
            end
            LOAD_B: begin
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (core_done) begin
                    out_valid_d  = 1'b1;
                    out_gcd_d    = core_result;
                    out_err_d    = GCD_OK;
                    out_cycles_d = cnt_inc;
                    state_d      = HOLD;
                end else if (cnt_inc >= MAX_RUN) begin
                    out_valid_d  = 1'b1;
                    out_gcd_d    = '0;
                    out_err_d    = GCD_TIMEOUT;
                    out_cycles_d = MAX_RUN;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    core_rst_n_d = 1'b0;
                    state_d      = REARM;
                end
            end
            default: begin
                core_rst_n_d = 1'b0;
                state_d      = REARM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REARM;
            op_b_q       <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_gcd_q    <= '0;
            out_err_q    <= GCD_OK;
            out_cycles_q <= '0;
            core_rst_n_q <= 1'b0;
            core_start_q <= 1'b0;
            core_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_b_q       <= op_b_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_gcd_q    <= out_gcd_d;
            out_err_q    <= out_err_d;
            out_cycles_q <= out_cycles_d;
            core_rst_n_q <= core_rst_n_d;
            core_start_q <= core_start_d;
            core_data_q  <= core_data_d;
        end
    end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural GCD core attached.
// The core model loads A on start, B on the next cycle, then performs one
// Euclid (mod) step per cycle and raises done one cycle after B reaches 0.
// Setting 'hang' freezes the core so it never finishes (timeout case).
module tb_gcd_job_sequencer;

    localparam int unsigned W  = 16;
    localparam logic [15:0] MR = 16'd8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_gcd;
    logic [1:0]    out_err;
    logic [15:0]   out_cycles;
    logic          core_rst_n;
    logic          core_start;
    logic [W-1:0]  core_data;
    logic          core_done;
    logic [W-1:0]  core_result;

    int n_checks = 0;
    int n_fail   = 0;

    gcd_job_sequencer #(
        .WIDTH   (W),
        .DEPTH   (4),
        .MAX_RUN (MR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_gcd     (out_gcd),
        .out_err     (out_err),
        .out_cycles  (out_cycles),
        .core_rst_n  (core_rst_n),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_done   (core_done),
        .core_result (core_result)
    );

    always #5 clk = ~clk;

    // Behavioural core.
    logic         hang = 1'b0;
    logic [1:0]   cst;
    logic [W-1:0] ca, cb;
    logic         cdone;

    always @(posedge clk) begin
        if (!core_rst_n) begin
            cst   <= 2'd0;
            ca    <= '0;
            cb    <= '0;
            cdone <= 1'b0;
        end else begin
            case (cst)
                2'd0: if (core_start) begin ca <= core_data; cst <= 2'd1; end
                2'd1: begin cb <= core_data; cst <= 2'd2; end
                2'd2: if (!hang) begin
                    if (cb == '0) begin
                        cdone <= 1'b1;
                        cst   <= 2'd3;
                    end else begin
                        ca <= cb;
                        cb <= ca % cb;
                    end
                end
                default: ;
            endcase
        end
    end
    assign core_done   = cdone;
    assign core_result = ca;

    // Euclid mod-steps until B is zero; the sequencer then reports steps+2
    // RUN cycles (one for the core to raise done, one to observe it).
    function automatic int steps(input logic [15:0] a, input logic [15:0] b);
        int s = 0;
        logic [15:0] x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
            s++;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge sample point; waits (bounded) for out_valid, checks
    // the result and, when out_ready is high, that out_valid drops afterwards.
    task automatic wait_result(input string tag, input logic [15:0] eg, input logic [1:0] ee,
                               input logic [15:0] ec, output int waits);
        waits = 0;
        while (!out_valid && waits < 60) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_gcd"}, {16'd0, out_gcd}, {16'd0, eg});
        chk({tag, "_err"}, {30'd0, out_err}, {30'd0, ee});
        chk({tag, "_cycles"}, {16'd0, out_cycles}, {16'd0, ec});
        if (out_ready) begin
            @(negedge clk);
            chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    logic [15:0] pa [4] = '{16'd12, 16'd17, 16'd100, 16'd9};
    logic [15:0] pb [4] = '{16'd8,  16'd5,  16'd75,  16'd9};
    logic [15:0] pg [4] = '{16'd4,  16'd1,  16'd25,  16'd9};
    logic [15:0] q3a [6] = '{16'd12, 16'd35, 16'd17, 16'd9, 16'd100, 16'd6};
    logic [15:0] q3b [6] = '{16'd8,  16'd14, 16'd5,  16'd9, 16'd75,  16'd4};
    logic [15:0] q3g [5] = '{16'd4,  16'd7,  16'd1,  16'd9, 16'd25};
    int          w;
    logic        rec, seen_v, seen_s, pend;
    int          pushed, nres;
    logic [15:0] held_gcd, held_cyc;

    initial begin
        // Reset values while rst_n is low.
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_gcd", {16'd0, out_gcd}, 32'd0);
        chk("rst_out_err", {30'd0, out_err}, 32'd0);
        chk("rst_out_cycles", {16'd0, out_cycles}, 32'd0);
        chk("rst_core_start", {31'd0, core_start}, 32'd0);
        chk("rst_core_data", {16'd0, core_data}, 32'd0);
        chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        chk("rearm_low", {31'd0, core_rst_n}, 32'd0);
        @(negedge clk);
        chk("rearm_released", {31'd0, core_rst_n}, 32'd1);

        // Job (48,18): load sequence and result.
        in_valid = 1'b1; in_a = 16'd48; in_b = 16'd18;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_idle_start", {31'd0, core_start}, 32'd0);
        @(negedge clk);
        chk("t1_loada_start", {31'd0, core_start}, 32'd1);
        chk("t1_loada_data", {16'd0, core_data}, 32'd48);
        @(negedge clk);
        chk("t1_loadb_start", {31'd0, core_start}, 32'd0);
        chk("t1_loadb_data", {16'd0, core_data}, 32'd18);
        @(negedge clk);
        chk("t1_run_data", {16'd0, core_data}, 32'd0);
        chk("t1_run_start", {31'd0, core_start}, 32'd0);
        wait_result("t1", 16'd6, 2'd0, 16'(steps(16'd48, 16'd18) + 2), w);

        // Zero operand: result in the second cycle after accept, core untouched.
        in_valid = 1'b1; in_a = 16'd0; in_b = 16'd7;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t2_early_valid", {31'd0, out_valid}, 32'd0);
        chk("t2_start_a", {31'd0, core_start}, 32'd0);
        @(negedge clk);
        chk("t2_start_b", {31'd0, core_start}, 32'd0);
        wait_result("t2", 16'd0, 2'd1, 16'd0, w);
        chk("t2_latency", w, 32'd0);

        // Backpressure: 6 pushes, 5 accepted, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_a = q3a[i]; in_b = q3b[i];
            rec = in_ready;
            @(negedge clk);
            chk($sformatf("t3_accept%0d", i), {31'd0, rec}, (i < 5) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
        chk("t3_held_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_result($sformatf("t3_r%0d", i), q3g[i], 2'd0,
                        16'(steps(q3a[i], q3b[i]) + 2), w);
        end
        chk("t3_ready_after", {31'd0, in_ready}, 32'd1);

        // Timeout with a core that never finishes.
        hang = 1'b1;
        in_valid = 1'b1; in_a = 16'd21; in_b = 16'd6;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("t4", 16'd0, 2'd2, 16'd8, w);
        chk("t4_latency", w, 32'd11);
        hang = 1'b0;

        // Asynchronous reset in RUN with two pairs buffered.
        in_valid = 1'b1; in_a = 16'd48; in_b = 16'd18;
        @(negedge clk);
        in_a = 16'd12; in_b = 16'd8;
        @(negedge clk);
        in_a = 16'd35; in_b = 16'd14;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_pre_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_out_err", {30'd0, out_err}, 32'd0);
        chk("t5_out_cycles", {16'd0, out_cycles}, 32'd0);
        chk("t5_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        chk("t5_core_start", {31'd0, core_start}, 32'd0);
        chk("t5_core_data", {16'd0, core_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rearm_one", {31'd0, core_rst_n}, 32'd1);
        seen_v = 1'b0; seen_s = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen_v = seen_v | out_valid;
            seen_s = seen_s | core_start;
        end
        chk("t5_no_result", {31'd0, seen_v}, 32'd0);
        chk("t5_no_start", {31'd0, seen_s}, 32'd0);

        // Held in_valid with toggling out_ready: order and stability.
        pushed = 0; nres = 0; pend = 1'b0;
        for (int cyc = 0; cyc < 400 && nres < 4; cyc++) begin
            in_valid  = (pushed < 4);
            in_a      = pa[pushed % 4];
            in_b      = pb[pushed % 4];
            out_ready = (cyc % 3 == 2);
            if (pend) begin
                chk("t6_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("t6_hold_gcd", {16'd0, out_gcd}, {16'd0, held_gcd});
                chk("t6_hold_cycles", {16'd0, out_cycles}, {16'd0, held_cyc});
            end
            if (in_valid && in_ready) pushed++;
            if (out_valid) begin
                if (out_ready) begin
                    chk($sformatf("t6_gcd%0d", nres), {16'd0, out_gcd}, {16'd0, pg[nres]});
                    chk($sformatf("t6_err%0d", nres), {30'd0, out_err}, 32'd0);
                    chk($sformatf("t6_cyc%0d", nres), {16'd0, out_cycles},
                        steps(pa[nres], pb[nres]) + 2);
                    nres++;
                    pend = 1'b0;
                end else begin
                    pend     = 1'b1;
                    held_gcd = out_gcd;
                    held_cyc = out_cycles;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t6_results", nres, 32'd4);
        chk("t6_pushed", pushed, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required end within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
